// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath (master) and pipe_ctrl (slave).
interface pipe_ctrl_if;
  logic        i_ce;
  logic [4:0]  i_id_rs1;
  logic [4:0]  i_id_rs2;
  logic        i_id_use_rs1;
  logic        i_id_use_rs2;
  logic [4:0]  i_ex_rd;
  logic        i_ex_is_load;
  logic        i_ex_br_taken;
  logic        i_mem_req;
  logic        i_mem_ack;
  logic        o_if_ce;
  logic        o_id_ce;
  logic        o_ex_ce;
  logic        o_mem_ce;
  logic        o_wb_ce;
  logic        o_id_flush;
  logic        o_ex_flush;
  logic        o_mem_err;
  logic [15:0] o_stall_cnt;

  modport master (
    output i_ce, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2, i_ex_rd, i_ex_is_load,
           i_ex_br_taken, i_mem_req, i_mem_ack,
    input  o_if_ce, o_id_ce, o_ex_ce, o_mem_ce, o_wb_ce, o_id_flush, o_ex_flush, o_mem_err,
           o_stall_cnt
  );

  modport slave (
    input  i_ce, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2, i_ex_rd, i_ex_is_load,
           i_ex_br_taken, i_mem_req, i_mem_ack,
    output o_if_ce, o_id_ce, o_ex_ce, o_mem_ce, o_wb_ce, o_id_flush, o_ex_flush, o_mem_err,
           o_stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline hazard/stall controller: load-use stall, branch flush, memory wait/timeout.
// Optional stall-cycle performance counter enabled by macro PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 15
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StRun, StFlush, StMemWait} state_e;

  localparam logic [1:0] FlushRem = 2'(FLUSH_CYCLES - 1);
  localparam logic [7:0] Timeout  = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [1:0] flush_rem_q, flush_rem_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  logic if_ce, id_ce, back_ce, id_flush, ex_flush, mem_err;
  logic mem_stall, load_use;

  assign mem_stall = bus.i_mem_req & ~bus.i_mem_ack;
  assign load_use  = bus.i_ex_is_load & (bus.i_ex_rd != 5'd0) &
                     ((bus.i_id_use_rs1 & (bus.i_id_rs1 == bus.i_ex_rd)) |
                      (bus.i_id_use_rs2 & (bus.i_id_rs2 == bus.i_ex_rd)));

  always_comb begin
    state_d     = state_q;
    flush_rem_d = flush_rem_q;
    wait_cnt_d  = wait_cnt_q;
    if_ce       = 1'b1;
    id_ce       = 1'b1;
    back_ce     = 1'b1;
    id_flush    = 1'b0;
    ex_flush    = 1'b0;
    mem_err     = 1'b0;

    if (!bus.i_ce) begin
      if_ce   = 1'b0;
      id_ce   = 1'b0;
      back_ce = 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (mem_stall) begin
            if_ce      = 1'b0;
            id_ce      = 1'b0;
            back_ce    = 1'b0;
            state_d    = StMemWait;
            wait_cnt_d = 8'd1;
          end else if (bus.i_ex_br_taken) begin
            id_flush = 1'b1;
            ex_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d     = StFlush;
              flush_rem_d = FlushRem;
            end
          end else if (load_use) begin
            if_ce    = 1'b0;
            id_ce    = 1'b0;
            ex_flush = 1'b1;
          end
        end
        StFlush: begin
          // A stalled flush cycle is not consumed; the remainder survives MEM_WAIT.
          if (mem_stall) begin
            if_ce      = 1'b0;
            id_ce      = 1'b0;
            back_ce    = 1'b0;
            state_d    = StMemWait;
            wait_cnt_d = 8'd1;
          end else begin
            id_flush    = 1'b1;
            flush_rem_d = flush_rem_q - 2'd1;
            if (flush_rem_q <= 2'd1) begin
              state_d = StRun;
            end
          end
        end
        StMemWait: begin
          if (bus.i_mem_ack) begin
            state_d    = (flush_rem_q != 2'd0) ? StFlush : StRun;
            wait_cnt_d = 8'd0;
          end else if (wait_cnt_q >= Timeout) begin
            mem_err     = 1'b1;
            state_d     = StRun;
            flush_rem_d = 2'd0;
            wait_cnt_d  = 8'd0;
          end else begin
            if_ce      = 1'b0;
            id_ce      = 1'b0;
            back_ce    = 1'b0;
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
        default: state_d = StRun;
      endcase
    end

    // Reset forces a frozen pipeline with bubbles in both IF/ID and ID/EX.
    if (rst) begin
      if_ce    = 1'b0;
      id_ce    = 1'b0;
      back_ce  = 1'b0;
      id_flush = 1'b1;
      ex_flush = 1'b1;
      mem_err  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      flush_rem_q <= 2'd0;
      wait_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      flush_rem_q <= flush_rem_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign bus.o_if_ce    = if_ce;
  assign bus.o_id_ce    = id_ce;
  assign bus.o_ex_ce    = back_ce;
  assign bus.o_mem_ce   = back_ce;
  assign bus.o_wb_ce    = back_ce;
  assign bus.o_id_flush = id_flush;
  assign bus.o_ex_flush = ex_flush;
  assign bus.o_mem_err  = mem_err;

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.i_ce && !if_ce && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.o_stall_cnt = stall_cnt_q;
`else
  assign bus.o_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=4).
module tb_pipe_ctrl;

  // {if, id, ex, mem, wb, id_flush, ex_flush, mem_err}
  localparam logic [7:0] ERun   = 8'b11111_00_0;
  localparam logic [7:0] ELu    = 8'b00111_01_0;
  localparam logic [7:0] EBr    = 8'b11111_11_0;
  localparam logic [7:0] EFl    = 8'b11111_10_0;
  localparam logic [7:0] EStall = 8'b00000_00_0;
  localparam logic [7:0] EErr   = 8'b11111_00_1;
  localparam logic [7:0] ERst   = 8'b00000_11_0;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   exp_stall;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .FLUSH_CYCLES(2),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.i_ce          = 1'b1;
    bus.i_id_rs1      = 5'd0;
    bus.i_id_rs2      = 5'd0;
    bus.i_id_use_rs1  = 1'b0;
    bus.i_id_use_rs2  = 1'b0;
    bus.i_ex_rd       = 5'd0;
    bus.i_ex_is_load  = 1'b0;
    bus.i_ex_br_taken = 1'b0;
    bus.i_mem_req     = 1'b0;
    bus.i_mem_ack     = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
    bus.i_ex_is_load = 1'b1;
    bus.i_ex_rd      = rd;
    bus.i_id_rs1     = rs1;
    bus.i_id_use_rs1 = u1;
    bus.i_id_rs2     = rs2;
    bus.i_id_use_rs2 = u2;
  endtask

  // Inputs are set just after a rising edge; outputs are checked 2 ns later, then one cycle runs.
  task automatic step(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    #2;
    obs = {bus.o_if_ce, bus.o_id_ce, bus.o_ex_ce, bus.o_mem_ce, bus.o_wb_ce,
           bus.o_id_flush, bus.o_ex_flush, bus.o_mem_err};
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    if (!rst && bus.i_ce && !exp[7]) exp_stall++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    logic [15:0] exp;
`ifdef PIPE_CTRL_PERF_EN
    exp = (exp_stall > 65535) ? 16'hFFFF : 16'(exp_stall);
`else
    exp = 16'h0000;
`endif
    n_cmp++;
    assert (bus.o_stall_cnt === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, bus.o_stall_cnt, exp);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    exp_stall = 0;
    rst       = 1'b1;
    idle();
    step("reset", ERst);
    chk_cnt("cnt_reset");
    rst = 1'b0;
    step("run_idle", ERun);

    // Load-use hazards
    set_lu(5'd6, 5'd6, 1'b1, 5'd0, 1'b0);
    step("lu_rs1", ELu);
    idle();
    step("lu_after", ERun);
    set_lu(5'd6, 5'd3, 1'b1, 5'd6, 1'b1);
    step("lu_rs2", ELu);
    set_lu(5'd6, 5'd6, 1'b0, 5'd6, 1'b0);
    step("lu_nouse", ERun);
    set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    step("lu_x0", ERun);
    idle();

    // Branch flush, two cycles
    bus.i_ex_br_taken = 1'b1;
    step("br_c0", EBr);
    idle();
    step("br_c1", EFl);
    step("br_c2", ERun);
    bus.i_ex_br_taken = 1'b1;
    set_lu(5'd6, 5'd6, 1'b1, 5'd0, 1'b0);
    step("br_over_lu", EBr);
    idle();
    step("br_over_lu_c1", EFl);

    // Memory wait, ack on t3
    bus.i_mem_req = 1'b1;
    step("mem_t0", EStall);
    step("mem_t1", EStall);
    step("mem_t2", EStall);
    bus.i_mem_ack = 1'b1;
    step("mem_t3_ack", ERun);
    step("mem_same", ERun);
    idle();

    // Timeout after 4 stalled cycles
    bus.i_mem_req = 1'b1;
    step("to_s0", EStall);
    step("to_s1", EStall);
    step("to_s2", EStall);
    step("to_s3", EStall);
    step("to_err", EErr);
    idle();
    step("to_after", ERun);

    // Req + branch + load-use together
    bus.i_mem_req     = 1'b1;
    bus.i_ex_br_taken = 1'b1;
    set_lu(5'd6, 5'd6, 1'b1, 5'd0, 1'b0);
    step("all_s0", EStall);
    step("all_s1", EStall);
    bus.i_mem_ack = 1'b1;
    step("all_ack", ERun);
    bus.i_mem_req = 1'b0;
    bus.i_mem_ack = 1'b0;
    step("all_br", EBr);
    idle();
    step("all_fl", EFl);
    step("all_run", ERun);

    // Memory stall inside FLUSH keeps the remainder
    bus.i_ex_br_taken = 1'b1;
    step("fm_br", EBr);
    idle();
    bus.i_mem_req = 1'b1;
    step("fm_stall", EStall);
    bus.i_mem_ack = 1'b1;
    step("fm_ack", ERun);
    idle();
    step("fm_fl", EFl);
    step("fm_run", ERun);

    // i_ce low holds the wait counter and the state
    bus.i_mem_req = 1'b1;
    step("ce_s0", EStall);
    bus.i_ce = 1'b0;
    step("ce_off0", EStall);
    step("ce_off1", EStall);
    step("ce_off2", EStall);
    bus.i_ce = 1'b1;
    step("ce_s1", EStall);
    step("ce_s2", EStall);
    step("ce_s3", EStall);
    step("ce_err", EErr);
    idle();
    bus.i_ce          = 1'b0;
    bus.i_ex_br_taken = 1'b1;
    step("ce_off_br", EStall);
    bus.i_ce = 1'b1;
    step("ce_on_br", EBr);
    idle();
    step("ce_on_fl", EFl);

    // Reset mid MEM_WAIT and mid FLUSH
    bus.i_mem_req = 1'b1;
    step("rw_s0", EStall);
    step("rw_s1", EStall);
    rst = 1'b1;
    idle();
    step("rw_rst", ERst);
    exp_stall = 0;
    chk_cnt("cnt_rst_clear");
    rst = 1'b0;
    step("rw_run0", ERun);
    step("rw_run1", ERun);
    step("rw_run2", ERun);
    bus.i_ex_br_taken = 1'b1;
    step("rf_br", EBr);
    idle();
    rst = 1'b1;
    step("rf_rst", ERst);
    rst = 1'b0;
    step("rf_run", ERun);

    // Stall counter
    set_lu(5'd6, 5'd6, 1'b1, 5'd0, 1'b0);
    step("cnt_lu", ELu);
    idle();
    step("cnt_run", ERun);
    chk_cnt("cnt_seq");
`ifdef PIPE_CTRL_PERF_EN
    set_lu(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 70000; i++) @(posedge clk);
    #1;
    exp_stall = exp_stall + 70000;
    chk_cnt("cnt_sat");
    idle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
